// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - state encoding and constants for the instruction-memory loader
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/ins_mem_loader.sv
// rtl/ins_mem_loader.sv - byte-stream instruction-memory loader (header count, LE words, optional XOR trailer)
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module ins_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  loader_state_t state, nxt;
  logic [7:0]    n_words;
  logic [7:0]    word_idx;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_buf;
  logic          xfer;
  logic          last_byte;
  logic          last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign xfer      = in_valid && in_ready;
  assign last_byte = (byte_cnt == 2'(WORD_BYTES - 1));
  assign last_word = (({1'b0, word_idx} + 9'd1) >= {1'b0, n_words});

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (load_start) nxt = HDR;
      HDR:   if (xfer) nxt = ((in_byte == 8'd0) || (32'(in_byte) > DEPTH_WORDS)) ? ERR : DATA;
      DATA:  if (xfer && last_byte) nxt = WRITE;
`ifdef LOADER_CHECKSUM_EN
      WRITE: nxt = last_word ? CHK : DATA;
      CHK:   if (xfer) nxt = (in_byte == csum) ? DONE : ERR;
`else
      WRITE: nxt = last_word ? DONE : DATA;
`endif
      DONE:  nxt = IDLE;
      ERR:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      cpu_hold    <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      n_words     <= '0;
      word_idx    <= '0;
      byte_cnt    <= '0;
      word_buf    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state     <= nxt;
      in_ready  <= (nxt == HDR) || (nxt == DATA) || (nxt == CHK);
      cpu_hold  <= (nxt == HDR) || (nxt == DATA) || (nxt == WRITE) || (nxt == CHK);
      mem_wr_en <= (nxt == WRITE);
      case (state)
        IDLE: if (load_start) begin
          load_done <= 1'b0;
          load_err  <= 1'b0;
          word_idx  <= '0;
          byte_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
          csum      <= '0;
`endif
        end
        HDR: if (xfer) n_words <= in_byte;
        DATA: if (xfer) begin
          byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum     <= csum ^ in_byte;
`endif
          case (byte_cnt)
            2'd0: word_buf[7:0]   <= in_byte;
            2'd1: word_buf[15:8]  <= in_byte;
            2'd2: word_buf[23:16] <= in_byte;
            default: begin
              mem_wr_addr <= ADDR_W'({word_idx, 2'b00});
              mem_wr_data <= {in_byte, word_buf};
            end
          endcase
        end
        WRITE: word_idx <= word_idx + 8'd1;
        default: ;
      endcase
      if (nxt == DONE) load_done <= 1'b1;
      if (nxt == ERR)  load_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// tb/tb_ins_mem_loader.sv - scoreboard bench for ins_mem_loader
module tb_ins_mem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready;
  logic       mem_wr_en;
  logic [7:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  ins_mem_loader #(.DEPTH_WORDS(64), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_byte(in_byte), .in_ready(in_ready), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;
  wr_t exp_wr[$];
  logic [1:0] exp_res[$];
  logic [7:0] stim[$];
  logic prev_flag = 1'b0;
  logic flag_now;
  wr_t w;
  logic [1:0] r;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and load outcomes as the DUT presents them.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=0x%0h@0x%0h required=none", mem_wr_data, mem_wr_addr);
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(mem_wr_addr), 32'(w.addr));
        check("wr_data", mem_wr_data, w.data);
        check("in_ready_during_write", 32'(in_ready), 32'd0);
      end
    end
    flag_now = load_done | load_err;
    if (flag_now && !prev_flag) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%b required=none", {load_done, load_err});
      end else begin
        r = exp_res.pop_front();
        check("result_done_err", 32'({load_done, load_err}), 32'(r));
        check("cpu_hold_at_end", 32'(cpu_hold), 32'd0);
      end
    end
    prev_flag = flag_now;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic with_byte);
    load_start = 1'b1;
    if (with_byte) begin
      in_valid = 1'b1;
      in_byte  = 8'h00;
    end
    tick();
    load_start = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    bit ok;
    ok = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_byte  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout actual=not_accepted required=accepted byte=0x%0h", b);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!cpu_hold) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL load_timeout actual=cpu_hold_high required=low");
    end
    tick();
  endtask

  task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (stim[i]) x ^= stim[i];
    stim.push_back(x);
`endif
  endtask

  task automatic run_load(input logic [7:0] hdr, input int gmax, input int mid_start_at, input logic with_byte);
    pulse_start(with_byte);
    send_byte(hdr, 0);
    foreach (stim[i]) begin
      if (i == mid_start_at) pulse_start(1'b0);
      send_byte(stim[i], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    end
    wait_idle();
  endtask

  task automatic push_basic();
    exp_wr.push_back('{8'h00, 32'h44332211});
    exp_wr.push_back('{8'h04, 32'h88776655});
    exp_res.push_back(2'b10);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h88);
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, "_mem_wr_addr"}, 32'(mem_wr_addr), 32'd0);
    check({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) tick();

    // Basic two-word load, with a byte offered alongside load_start.
    push_basic();
    run_load(8'd2, 0, -1, 1'b1);
    repeat (2) tick();
    check("basic_load_done_held", 32'(load_done), 32'd1);
    check("basic_load_err", 32'(load_err), 32'd0);
    check("basic_cpu_hold", 32'(cpu_hold), 32'd0);
    check("basic_addr_held", 32'(mem_wr_addr), 32'h04);
    check("basic_data_held", mem_wr_data, 32'h88776655);

    // Illegal headers.
    stim = {};
    exp_res.push_back(2'b01);
    run_load(8'd0, 0, -1, 1'b0);
    check("n0_load_err", 32'(load_err), 32'd1);
    check("n0_load_done_cleared", 32'(load_done), 32'd0);
    check("n0_cpu_hold", 32'(cpu_hold), 32'd0);
    exp_res.push_back(2'b01);
    run_load(8'd65, 0, -1, 1'b0);
    check("n65_load_err", 32'(load_err), 32'd1);
    check("n65_cpu_hold", 32'(cpu_hold), 32'd0);

    // Random gaps on in_valid.
    push_basic();
    run_load(8'd2, 3, -1, 1'b0);
    check("gaps_load_done", 32'(load_done), 32'd1);
    check("gaps_load_err_cleared", 32'(load_err), 32'd0);

    // load_start pulsed mid-DATA is ignored.
    push_basic();
    run_load(8'd2, 0, 5, 1'b0);
    check("midstart_load_done", 32'(load_done), 32'd1);

    // Maximum depth: word i bytes are 4i..4i+3, top address 0xFC.
    stim = {};
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 4; j++) stim.push_back(8'(4 * i + j));
      exp_wr.push_back('{8'(4 * i), {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)}});
    end
    add_csum();
    exp_res.push_back(2'b10);
    run_load(8'd64, 0, -1, 1'b0);
    check("max_depth_load_done", 32'(load_done), 32'd1);

    // Reset in the middle of the second word.
    exp_wr.push_back('{8'h00, 32'h44332211});
    pulse_start(1'b0);
    send_byte(8'd2, 0);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (stim[i]) send_byte(stim[i], 0);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("post_reset_cpu_hold", 32'(cpu_hold), 32'd0);
    check("post_reset_in_ready", 32'(in_ready), 32'd0);
    check("post_reset_mem_wr_en", 32'(mem_wr_en), 32'd0);
    stim = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    add_csum();
    exp_wr.push_back('{8'h00, 32'hD4C3B2A1});
    exp_res.push_back(2'b10);
    run_load(8'd1, 0, -1, 1'b0);
    check("post_reset_load_done", 32'(load_done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    exp_wr.push_back('{8'h00, 32'h08040201});
    exp_res.push_back(2'b10);
    run_load(8'd1, 0, -1, 1'b0);
    check("csum_good_done", 32'(load_done), 32'd1);
    stim = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    exp_wr.push_back('{8'h00, 32'h08040201});
    exp_res.push_back(2'b01);
    run_load(8'd1, 0, -1, 1'b0);
    check("csum_bad_err", 32'(load_err), 32'd1);
    check("csum_bad_done", 32'(load_done), 32'd0);
`endif

    repeat (3) tick();
    check("writes_outstanding", exp_wr.size(), 32'd0);
    check("results_outstanding", exp_res.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
